// File: rtl/axil_cdc_rd_pkg.sv
// Shared types and constants for the AXI4-lite read-channel clock domain crossing.
package axil_cdc_rd_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned SyncStages   = 2;

  typedef enum logic [1:0] {
    StSIdle = 2'd0,
    StSReq  = 2'd1,
    StSResp = 2'd2
  } s_state_e;

  typedef enum logic [1:0] {
    StMIdle = 2'd0,
    StMBusy = 2'd1,
    StMDone = 2'd2
  } m_state_e;

  // The slave side may take a new AR only once the previous request and its response have both
  // drained.
  function automatic logic ar_ready(input logic arvalid_held, input logic rvalid_held);
    return !arvalid_held && !rvalid_held;
  endfunction

endpackage

// File: rtl/axil_cdc_rd_if.sv
// AXI4-lite read-channel bundle (AR + R); master drives AR and rready, slave drives the rest.
interface axil_cdc_rd_if
  import axil_cdc_rd_pkg::*;
#(
  parameter int unsigned AddrWidth = DefAddrWidth,
  parameter int unsigned DataWidth = DefDataWidth
);

  logic [AddrWidth-1:0] araddr;
  logic [2:0]           arprot;
  logic                 arvalid;
  logic                 arready;
  logic [DataWidth-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output araddr,
    output arprot,
    output arvalid,
    input  arready,
    input  rdata,
    input  rresp,
    input  rvalid,
    output rready
  );

  modport slave (
    input  araddr,
    input  arprot,
    input  arvalid,
    output arready,
    output rdata,
    output rresp,
    output rvalid,
    input  rready
  );

endinterface

// File: rtl/axil_cdc_rd_sync.sv
// Single-bit multi-flop synchroniser into the destination clock domain.
module axil_cdc_rd_sync
  import axil_cdc_rd_pkg::*;
#(
  parameter int unsigned Stages = SyncStages
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  (* srl_style = "register" *) logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/axil_cdc_rd.sv
// AXI4-lite read-channel CDC bridge: AR crosses s_clk -> m_clk, R returns m_clk -> s_clk through a
// single-outstanding 4-phase req/ack flag handshake.
module axil_cdc_rd
  import axil_cdc_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                 s_clk,
  input  logic                 s_rst,
  axil_cdc_rd_if.slave         s_axil,
  input  logic                 m_clk,
  input  logic                 m_rst,
  axil_cdc_rd_if.master        m_axil
);

  if (STRB_WIDTH * 8 != DATA_WIDTH) begin : gen_bad_strb
    $error("axil_cdc_rd: STRB_WIDTH must equal DATA_WIDTH/8");
  end

  // s_clk domain state
  s_state_e              s_state_q, s_state_d;
  logic                  s_flag_q, s_flag_d;
  logic                  s_arvalid_q, s_arvalid_d;
  logic [ADDR_WIDTH-1:0] s_araddr_q, s_araddr_d;
  logic [2:0]            s_arprot_q, s_arprot_d;
  logic                  s_rvalid_q, s_rvalid_d;
  logic [DATA_WIDTH-1:0] s_rdata_q, s_rdata_d;
  logic [1:0]            s_rresp_q, s_rresp_d;
  logic                  s_arready;
  logic                  m_flag_s;

  // m_clk domain state
  m_state_e              m_state_q, m_state_d;
  logic                  m_flag_q, m_flag_d;
  logic                  m_arvalid_q, m_arvalid_d;
  logic [ADDR_WIDTH-1:0] m_araddr_q, m_araddr_d;
  logic [2:0]            m_arprot_q, m_arprot_d;
  logic                  m_rvalid_q, m_rvalid_d;
  logic [DATA_WIDTH-1:0] m_rdata_q, m_rdata_d;
  logic [1:0]            m_rresp_q, m_rresp_d;
  logic                  s_flag_m;

  axil_cdc_rd_sync #(
    .Stages (SyncStages)
  ) u_sync_req (
    .clk_i (m_clk),
    .rst_i (m_rst),
    .d_i   (s_flag_q),
    .q_o   (s_flag_m)
  );

  axil_cdc_rd_sync #(
    .Stages (SyncStages)
  ) u_sync_ack (
    .clk_i (s_clk),
    .rst_i (s_rst),
    .d_i   (m_flag_q),
    .q_o   (m_flag_s)
  );

  // ---------------------------------------------------------------- s_clk domain
  assign s_arready = ar_ready(s_arvalid_q, s_rvalid_q);

  always_comb begin
    s_state_d   = s_state_q;
    s_flag_d    = s_flag_q;
    s_arvalid_d = s_arvalid_q;
    s_araddr_d  = s_araddr_q;
    s_arprot_d  = s_arprot_q;
    s_rvalid_d  = s_rvalid_q;
    s_rdata_d   = s_rdata_q;
    s_rresp_d   = s_rresp_q;

    // Address regs stay frozen from acceptance until RESP->IDLE, so m_clk may sample them freely.
    if (s_arready) begin
      s_arvalid_d = s_axil.arvalid;
      s_araddr_d  = s_axil.araddr;
      s_arprot_d  = s_axil.arprot;
    end
    if (s_axil.rready) begin
      s_rvalid_d = 1'b0;
    end

    case (s_state_q)
      StSIdle: begin
        if (s_arvalid_q) begin
          s_state_d = StSReq;
          s_flag_d  = 1'b1;
        end
      end
      StSReq: begin
        if (m_flag_s) begin
          s_state_d  = StSResp;
          s_flag_d   = 1'b0;
          s_rdata_d  = m_rdata_q;
          s_rresp_d  = m_rresp_q;
          s_rvalid_d = 1'b1;
        end
      end
      StSResp: begin
        if (!m_flag_s) begin
          s_state_d   = StSIdle;
          s_arvalid_d = 1'b0;
        end
      end
      default: s_state_d = StSIdle;
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      s_state_q   <= StSIdle;
      s_flag_q    <= 1'b0;
      s_arvalid_q <= 1'b0;
      s_araddr_q  <= '0;
      s_arprot_q  <= '0;
      s_rvalid_q  <= 1'b0;
      s_rdata_q   <= '0;
      s_rresp_q   <= '0;
    end else begin
      s_state_q   <= s_state_d;
      s_flag_q    <= s_flag_d;
      s_arvalid_q <= s_arvalid_d;
      s_araddr_q  <= s_araddr_d;
      s_arprot_q  <= s_arprot_d;
      s_rvalid_q  <= s_rvalid_d;
      s_rdata_q   <= s_rdata_d;
      s_rresp_q   <= s_rresp_d;
    end
  end

  assign s_axil.arready = s_arready;
  assign s_axil.rdata   = s_rdata_q;
  assign s_axil.rresp   = s_rresp_q;
  assign s_axil.rvalid  = s_rvalid_q;

  // ---------------------------------------------------------------- m_clk domain
  always_comb begin
    m_state_d   = m_state_q;
    m_flag_d    = m_flag_q;
    m_arvalid_d = m_arvalid_q;
    m_araddr_d  = m_araddr_q;
    m_arprot_d  = m_arprot_q;
    m_rvalid_d  = m_rvalid_q;
    m_rdata_d   = m_rdata_q;
    m_rresp_d   = m_rresp_q;

    // m_rvalid_q doubles as the "response held" flag: once set, R data is frozen for s_clk.
    if (!m_rvalid_q) begin
      m_rvalid_d = m_axil.rvalid;
      m_rdata_d  = m_axil.rdata;
      m_rresp_d  = m_axil.rresp;
    end
    if (m_axil.arready) begin
      m_arvalid_d = 1'b0;
    end

    case (m_state_q)
      StMIdle: begin
        if (s_flag_m) begin
          m_state_d   = StMBusy;
          m_araddr_d  = s_araddr_q;
          m_arprot_d  = s_arprot_q;
          m_arvalid_d = 1'b1;
          m_rvalid_d  = 1'b0;
        end
      end
      StMBusy: begin
        if (m_rvalid_q) begin
          m_state_d = StMDone;
          m_flag_d  = 1'b1;
        end
      end
      StMDone: begin
        if (!s_flag_m) begin
          m_state_d = StMIdle;
          m_flag_d  = 1'b0;
        end
      end
      default: m_state_d = StMIdle;
    endcase
  end

  always_ff @(posedge m_clk) begin
    if (m_rst) begin
      m_state_q   <= StMIdle;
      m_flag_q    <= 1'b0;
      m_arvalid_q <= 1'b0;
      m_araddr_q  <= '0;
      m_arprot_q  <= '0;
      m_rvalid_q  <= 1'b1;
      m_rdata_q   <= '0;
      m_rresp_q   <= '0;
    end else begin
      m_state_q   <= m_state_d;
      m_flag_q    <= m_flag_d;
      m_arvalid_q <= m_arvalid_d;
      m_araddr_q  <= m_araddr_d;
      m_arprot_q  <= m_arprot_d;
      m_rvalid_q  <= m_rvalid_d;
      m_rdata_q   <= m_rdata_d;
      m_rresp_q   <= m_rresp_d;
    end
  end

  assign m_axil.araddr  = m_araddr_q;
  assign m_axil.arprot  = m_arprot_q;
  assign m_axil.arvalid = m_arvalid_q;
  assign m_axil.rready  = !m_rvalid_q;

endmodule

// File: tb/tb_axil_cdc_rd.sv
// Self-checking bench for axil_cdc_rd: directed and random reads across varying clock ratios,
// with a behavioural m-side memory slave and an in-order AR scoreboard.
module tb_axil_cdc_rd;

  logic s_clk;
  logic s_rst;
  logic m_clk;
  logic m_rst;
  int   m_half = 18;

  int total    = 0;
  int bad      = 0;
  int s_ar_cnt = 0;
  int m_ar_cnt = 0;

  logic [34:0] m_ar_q[$];
  logic [33:0] ovr[logic [31:0]];

  axil_cdc_rd_if s_if ();
  axil_cdc_rd_if m_if ();

  axil_cdc_rd dut (
    .s_clk  (s_clk),
    .s_rst  (s_rst),
    .s_axil (s_if),
    .m_clk  (m_clk),
    .m_rst  (m_rst),
    .m_axil (m_if)
  );

  initial begin
    s_clk = 1'b0;
    forever #6 s_clk = ~s_clk;
  end

  initial begin
    m_clk = 1'b0;
    forever #(m_half) m_clk = ~m_clk;
  end

  // Memory contents seen by the m-side slave: {rresp, rdata}; addr bit 2 selects SLVERR.
  function automatic logic [33:0] slave_word(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return {(a[2] ? 2'b10 : 2'b00), (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // m-side AXI-lite slave with random AR and R stalls.
  initial begin
    logic [31:0] a;
    logic [2:0]  p;
    logic [33:0] w;
    int          n;
    m_if.arready = 1'b0;
    m_if.rvalid  = 1'b0;
    m_if.rdata   = '0;
    m_if.rresp   = '0;
    forever begin
      @(posedge m_clk);
      #1;
      if (m_if.arvalid === 1'b1) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge m_clk);
          #1;
        end
        a = m_if.araddr;
        p = m_if.arprot;
        m_if.arready = 1'b1;
        @(posedge m_clk);
        #1;
        m_if.arready = 1'b0;
        m_ar_q.push_back({p, a});
        m_ar_cnt++;
        check("m_arvalid_drop", 64'(m_if.arvalid), 64'd0);
        repeat ($urandom_range(0, 3)) begin
          @(posedge m_clk);
          #1;
        end
        w = slave_word(a);
        m_if.rdata  = w[31:0];
        m_if.rresp  = w[33:32];
        m_if.rvalid = 1'b1;
        n = 0;
        while (m_if.rready !== 1'b1 && n < 200) begin
          @(posedge m_clk);
          #1;
          n++;
        end
        check("m_rready_timeout", 64'(n < 200), 64'd1);
        @(posedge m_clk);
        #1;
        m_if.rvalid = 1'b0;
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, input logic [2:0] prot, input int hold);
    logic [33:0] exp_w;
    logic [34:0] got;
    int          n;
    exp_w = slave_word(addr);
    s_if.araddr  = addr;
    s_if.arprot  = prot;
    s_if.arvalid = 1'b1;
    n = 0;
    while (s_if.arready !== 1'b1 && n < 400) begin
      @(posedge s_clk);
      #1;
      n++;
    end
    check("s_arready_timeout", 64'(n < 400), 64'd1);
    if (n >= 400) begin
      s_if.arvalid = 1'b0;
      return;
    end
    @(posedge s_clk);
    #1;
    s_if.arvalid = 1'b0;
    s_ar_cnt++;
    n = 0;
    while (s_if.rvalid !== 1'b1 && n < 400) begin
      @(posedge s_clk);
      #1;
      n++;
    end
    check("s_rvalid_timeout", 64'(n < 400), 64'd1);
    if (n >= 400) return;
    check("s_rdata", 64'(s_if.rdata), 64'(exp_w[31:0]));
    check("s_rresp", 64'(s_if.rresp), 64'(exp_w[33:32]));
    check("s_arready_busy", 64'(s_if.arready), 64'd0);
    check("m_ar_per_s_ar", 64'(m_ar_q.size()), 64'd1);
    if (m_ar_q.size() > 0) begin
      got = m_ar_q.pop_front();
      check("m_araddr", 64'(got[31:0]), 64'(addr));
      check("m_arprot", 64'(got[34:32]), 64'(prot));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge s_clk);
      #1;
      check("hold_rvalid", 64'(s_if.rvalid), 64'd1);
      check("hold_rdata", 64'(s_if.rdata), 64'(exp_w[31:0]));
      check("hold_arready", 64'(s_if.arready), 64'd0);
    end
    s_if.rready = 1'b1;
    @(posedge s_clk);
    #1;
    s_if.rready = 1'b0;
    check("rvalid_single_pulse", 64'(s_if.rvalid), 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [34:0] got;
    int          n;
    s_rst = 1'b1;
    m_rst = 1'b1;
    s_if.araddr  = '0;
    s_if.arprot  = '0;
    s_if.arvalid = 1'b0;
    s_if.rready  = 1'b0;
    repeat (4) @(posedge m_clk);
    @(posedge s_clk);
    #1;
    s_rst = 1'b0;
    m_rst = 1'b0;

    check("rst_s_arready", 64'(s_if.arready), 64'd1);
    check("rst_s_rvalid", 64'(s_if.rvalid), 64'd0);
    check("rst_s_rdata", 64'(s_if.rdata), 64'd0);
    check("rst_s_rresp", 64'(s_if.rresp), 64'd0);
    check("rst_m_arvalid", 64'(m_if.arvalid), 64'd0);
    check("rst_m_rready", 64'(m_if.rready), 64'd0);

    // Directed reads with m_clk three times slower than s_clk.
    ovr[32'h0000_1000] = {2'b00, 32'hDEAD_BEEF};
    do_read(32'h0000_1000, 3'b000, 0);
    ovr[32'h0000_2000] = {2'b10, 32'h0BAD_F00D};
    do_read(32'h0000_2000, 3'b000, 1);
    do_read(32'h0000_3000, 3'b010, 10);
    do_read(32'hFFFF_FFFC, 3'b101, 2);

    // Back-to-back random reads: m_clk fast, then slow.
    for (int i = 0; i < 16; i++) begin
      if (i == 0) m_half = 2;
      if (i == 8) m_half = 18;
      do_read($urandom, 3'($urandom_range(0, 7)), int'($urandom_range(0, 4)));
    end

    // Abort the s side while its request is outstanding on the m side.
    a = 32'h0000_4440;
    s_if.araddr  = a;
    s_if.arprot  = 3'b011;
    s_if.arvalid = 1'b1;
    n = 0;
    while (s_if.arready !== 1'b1 && n < 400) begin
      @(posedge s_clk);
      #1;
      n++;
    end
    @(posedge s_clk);
    #1;
    s_if.arvalid = 1'b0;
    s_ar_cnt++;
    n = 0;
    while (m_if.arvalid !== 1'b1 && n < 100) begin
      @(posedge m_clk);
      #1;
      n++;
    end
    check("abort_m_ar_seen", 64'(n < 100), 64'd1);
    s_rst = 1'b1;
    @(posedge s_clk);
    #1;
    s_rst = 1'b0;
    check("abort_rvalid", 64'(s_if.rvalid), 64'd0);
    check("abort_arready", 64'(s_if.arready), 64'd1);
    repeat (24) @(posedge m_clk);
    #1;
    check("abort_no_rvalid", 64'(s_if.rvalid), 64'd0);
    check("abort_m_ar_count", 64'(m_ar_q.size()), 64'd1);
    if (m_ar_q.size() > 0) begin
      got = m_ar_q.pop_front();
      check("abort_m_araddr", 64'(got[31:0]), 64'(a));
    end
    ovr[32'h0000_5550] = {2'b00, 32'hC0DE_CAFE};
    do_read(32'h0000_5550, 3'b001, 3);

    check("ar_count_match", 64'(m_ar_cnt), 64'(s_ar_cnt));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
